pipeline_stage1: RTL and testbench

Second pipeline stage of the CPU control path. Consumes the byte stream produced by stage 0 (`instruction_out`), assembles complete instructions (opcode plus 0–2 little-endian immediate bytes) and presents each finished instruction to the decode stage as a one-cycle `instr_valid` pulse. The stage also tells the bus/fetch logic when it is collecting operand bytes, and supports stall and flush from downstream control.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/pipeline_stage1_len_decode.sv | 22 ++
 rtl/pipeline_stage1.sv | 131 +++++++++++++
 tb/tb_pipeline_stage1.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared control-path definitions: FSM state encoding, length classes and
// the bubble opcode value used by the instruction-assembly stages.
package pipeline_pkg;

    typedef enum logic [1:0] {
        S_OPCODE = 2'd0,
        S_OPLO   = 2'd1,
        S_OPHI   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        LEN_1 = 2'd1,
        LEN_2 = 2'd2,
        LEN_3 = 2'd3
    } len_t;

    localparam int BUBBLE_OPCODE = 0;

endpackage

// File: rtl/pipeline_stage1_len_decode.sv
// Opcode -> instruction length class. The class lives in the top two opcode
// bits; 2'b11 is treated as a single-byte instruction like 2'b00.
module pipeline_stage1_len_decode
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] opcode,
    output len_t             len
);

    // Pure decode of the length field.
    always_comb begin
        len = LEN_1;
        case (opcode[WIDTH-1 -: 2])
            2'b01:   len = LEN_2;
            2'b10:   len = LEN_3;
            default: len = LEN_1;
        endcase
    end

endmodule

// File: rtl/pipeline_stage1.sv
// Instruction assembly stage: collects opcode plus 0-2 little-endian operand
// bytes and reports each finished instruction with a one-cycle instr_valid.
// Optional completed-instruction counter: define PIPELINE_STAGE1_INSTR_COUNT_EN.
module pipeline_stage1
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   instruction_in,
    input  logic               stall,
    input  logic               flush,
    output logic [WIDTH-1:0]   opcode_out,
    output logic [2*WIDTH-1:0] imm_out,
    output logic               instr_valid,
    output logic               operand_fetch,
    output logic [15:0]        instr_count
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opcode_out_q, opcode_out_d;
    logic [2*WIDTH-1:0] imm_out_q, imm_out_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   dec_opcode;
    len_t               dec_len;

    // While waiting for an opcode the class comes from the incoming byte;
    // in operand states it comes from the held opcode.
    assign dec_opcode = (state_q == S_OPCODE) ? instruction_in : op_q;

    pipeline_stage1_len_decode #(.WIDTH(WIDTH)) u_len_decode (
        .opcode (dec_opcode),
        .len    (dec_len)
    );

    // Next-state and completion logic; flush beats stall beats normal flow.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        lo_d         = lo_q;
        opcode_out_d = opcode_out_q;
        imm_out_d    = imm_out_q;
        valid_d      = 1'b0;
        if (flush) begin
            state_d = S_OPCODE;
            op_d    = '0;
            lo_d    = '0;
        end else if (!stall) begin
            case (state_q)
                S_OPCODE: begin
                    if (instruction_in != WIDTH'(BUBBLE_OPCODE)) begin
                        op_d = instruction_in;
                        if (dec_len == LEN_1) begin
                            opcode_out_d = instruction_in;
                            imm_out_d    = '0;
                            valid_d      = 1'b1;
                        end else begin
                            state_d = S_OPLO;
                        end
                    end
                end
                S_OPLO: begin
                    lo_d = instruction_in;
                    if (dec_len == LEN_2) begin
                        opcode_out_d = op_q;
                        imm_out_d    = {{WIDTH{1'b0}}, instruction_in};
                        valid_d      = 1'b1;
                        state_d      = S_OPCODE;
                    end else begin
                        state_d = S_OPHI;
                    end
                end
                S_OPHI: begin
                    opcode_out_d = op_q;
                    imm_out_d    = {instruction_in, lo_q};
                    valid_d      = 1'b1;
                    state_d      = S_OPCODE;
                end
                default: state_d = S_OPCODE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_OPCODE;
            op_q         <= '0;
            lo_q         <= '0;
            opcode_out_q <= '0;
            imm_out_q    <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            lo_q         <= lo_d;
            opcode_out_q <= opcode_out_d;
            imm_out_q    <= imm_out_d;
            valid_q      <= valid_d;
        end
    end

    assign opcode_out    = opcode_out_q;
    assign imm_out       = imm_out_q;
    assign instr_valid   = valid_q;
    assign operand_fetch = (state_q != S_OPCODE);

`ifdef PIPELINE_STAGE1_INSTR_COUNT_EN
    logic [15:0] count_q, count_d;

    // Counts in step with the completion so the count is current when the
    // pulse is seen; wraps naturally at 16 bits.
    always_comb begin
        count_d = valid_d ? count_q + 16'd1 : count_q;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_stage1.sv
// Directed vector bench for pipeline_stage1 (WIDTH = 8).
module tb_pipeline_stage1;

`ifdef PIPELINE_STAGE1_INSTR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  instruction_in;
    logic        stall;
    logic        flush;
    logic [7:0]  opcode_out;
    logic [15:0] imm_out;
    logic        instr_valid;
    logic        operand_fetch;
    logic [15:0] instr_count;

    pipeline_stage1 #(.WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instruction_in (instruction_in),
        .stall          (stall),
        .flush          (flush),
        .opcode_out     (opcode_out),
        .imm_out        (imm_out),
        .instr_valid    (instr_valid),
        .operand_fetch  (operand_fetch),
        .instr_count    (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        fl;
        logic [7:0]  din;
        logic        v;
        logic [7:0]  op;
        logic [15:0] imm;
        logic        of;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   total  = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] ecnt(input logic [15:0] c);
        return CNT_EN ? c : 16'd0;
    endfunction

    task automatic add(input logic st, input logic fl, input logic [7:0] din,
                       input logic v, input logic [7:0] op, input logic [15:0] imm,
                       input logic of, input logic [15:0] cnt);
        vec_t r;
        r.st = st; r.fl = fl; r.din = din; r.v = v;
        r.op = op; r.imm = imm; r.of = of; r.cnt = cnt;
        vecs.push_back(r);
    endtask

    initial begin
        // stall, flush, input -> valid, opcode, imm, operand_fetch, count
        add(0,0,8'h12, 1,8'h12,16'h0000,0,1);  // byte held through reset
        add(0,0,8'h00, 0,8'h12,16'h0000,0,1);
        add(0,0,8'h45, 0,8'h12,16'h0000,1,1);  // 2-byte
        add(0,0,8'hAB, 1,8'h45,16'h00AB,0,2);
        add(0,0,8'h85, 0,8'h45,16'h00AB,1,2);  // 3-byte
        add(0,0,8'h34, 0,8'h45,16'h00AB,1,2);
        add(0,0,8'h12, 1,8'h85,16'h1234,0,3);
        add(0,0,8'h85, 0,8'h85,16'h1234,1,3);  // zero operand byte
        add(0,0,8'h00, 0,8'h85,16'h1234,1,3);
        add(0,0,8'h12, 1,8'h85,16'h1200,0,4);
        add(0,0,8'h85, 0,8'h85,16'h1200,1,4);  // stall in S_OPHI
        add(0,0,8'h34, 0,8'h85,16'h1200,1,4);
        add(1,0,8'h12, 0,8'h85,16'h1200,1,4);
        add(1,0,8'h55, 0,8'h85,16'h1200,1,4);
        add(1,0,8'h00, 0,8'h85,16'h1200,1,4);
        add(0,0,8'h12, 1,8'h85,16'h1234,0,5);
        add(0,0,8'h85, 0,8'h85,16'h1234,1,5);  // flush with final byte
        add(0,0,8'h34, 0,8'h85,16'h1234,1,5);
        add(0,1,8'h12, 0,8'h85,16'h1234,0,5);
        add(0,0,8'h12, 1,8'h12,16'h0000,0,6);
        add(0,0,8'h00, 0,8'h12,16'h0000,0,6);  // bubbles
        add(0,0,8'h00, 0,8'h12,16'h0000,0,6);
        add(0,0,8'h00, 0,8'h12,16'h0000,0,6);
        add(0,0,8'h00, 0,8'h12,16'h0000,0,6);
        add(0,0,8'hC3, 1,8'hC3,16'h0000,0,7);  // back-to-back 1-byte
        add(0,0,8'h3F, 1,8'h3F,16'h0000,0,8);
        add(0,0,8'h45, 0,8'h3F,16'h0000,1,8);  // flush beats stall
        add(1,1,8'hAB, 0,8'h3F,16'h0000,0,8);
        add(0,0,8'h01, 1,8'h01,16'h0000,0,9);
        add(1,0,8'h02, 0,8'h01,16'h0000,0,9);  // stall after completion: no repeat

        // Reset with input held at 0x12.
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; instruction_in = 8'h12;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_opcode", 32'(opcode_out), 32'h0);
        chk("rst_imm", 32'(imm_out), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_opfetch", 32'(operand_fetch), 32'h0);
        chk("rst_count", 32'(instr_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven section.
        foreach (vecs[i]) begin
            @(negedge clk);
            stall = vecs[i].st; flush = vecs[i].fl; instruction_in = vecs[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].v));
            chk($sformatf("v%0d_opcode", i), 32'(opcode_out), 32'(vecs[i].op));
            chk($sformatf("v%0d_imm", i), 32'(imm_out), 32'(vecs[i].imm));
            chk($sformatf("v%0d_opfetch", i), 32'(operand_fetch), 32'(vecs[i].of));
            chk($sformatf("v%0d_count", i), 32'(instr_count), 32'(ecnt(vecs[i].cnt)));
        end

        // Asynchronous reset in the middle of a 3-byte instruction.
        @(negedge clk); stall = 1'b0; instruction_in = 8'h85;
        @(negedge clk); instruction_in = 8'h34;
        @(posedge clk); #1;
        chk("mid_opfetch_before", 32'(operand_fetch), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_opfetch", 32'(operand_fetch), 32'h0);
        chk("mid_rst_opcode", 32'(opcode_out), 32'h0);
        chk("mid_rst_valid", 32'(instr_valid), 32'h0);
        chk("mid_rst_count", 32'(instr_count), 32'h0);
        @(negedge clk); instruction_in = 8'h12;
        @(posedge clk); #1;
        chk("mid_rst_hold_valid", 32'(instr_valid), 32'h0);

        // Counter wrap: 65536 one-byte instructions back to back.
        @(negedge clk); instruction_in = 8'h01; rst_n = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        chk("wrap_ffff", 32'(instr_count), 32'(ecnt(16'hFFFF)));
        chk("wrap_valid", 32'(instr_valid), 32'h1);
        @(posedge clk); #1;
        chk("wrap_zero", 32'(instr_count), 32'h0);
        chk("wrap_opcode", 32'(opcode_out), 32'h01);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
